// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the AES-128 decryption controller and the datapath it
// steers: FSM state encoding, datapath mux select codes, round/column limits.
// The datapath decodes SEL, COL and ROUND_KEY_IDX using these constants only.
// -----------------------------------------------------------------------------
package aes_pkg;

   // AES-128: ten rounds, four columns per state matrix.
   localparam logic [3:0] NUM_ROUNDS = 4'd10;
   localparam int unsigned MIX_COLS  = 4;

   // Last round that runs the full loop (the final round has no InvMixColumns).
   localparam logic [3:0] LAST_LOOP_ROUND = NUM_ROUNDS - 4'd1;
   // Last column index visited while in InvMixColumns.
   localparam logic [1:0] COL_LAST = 2'(MIX_COLS - 1);

   // Datapath mux select encoding.
   localparam logic [1:0] SEL_ARK = 2'b00;   // AddRoundKey
   localparam logic [1:0] SEL_ISR = 2'b01;   // InvShiftRows
   localparam logic [1:0] SEL_ISB = 2'b10;   // InvSubBytes
   localparam logic [1:0] SEL_IMC = 2'b11;   // InvMixColumns

   // Controller states.
   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_LOAD    = 4'd1,
      ST_KEYWAIT = 4'd2,
      ST_ARK0    = 4'd3,
      ST_ISR     = 4'd4,
      ST_ISB     = 4'd5,
      ST_ARK     = 4'd6,
      ST_IMC     = 4'd7,
      ST_FISR    = 4'd8,
      ST_FISB    = 4'd9,
      ST_FARK    = 4'd10,
      ST_DONE    = 4'd11
   } aes_state_t;

endpackage

// File: rtl/aes_dec_ctrl.sv
// -----------------------------------------------------------------------------
// aes_dec_ctrl
// Sequencer for an iterative AES-128 decryption datapath. One FSM plus a round
// counter (1..9) and an InvMixColumns column counter (0..3). Every output is a
// decode of the state/counter registers, so no input reaches an output
// combinationally.
//
// Ports
//   i_clk            rising-edge clock
//   i_reset_n        synchronous active-low reset
//   i_aes_start      level request; only looked at in IDLE and DONE
//   i_key_ready      key schedule valid; only looked at in KEYWAIT
//   o_aes_done       high while in DONE
//   o_busy           high in every state except IDLE and DONE
//   o_key_go         one-cycle pulse starting key expansion
//   o_load_msg       state register loads ciphertext
//   o_update         state register loads datapath result
//   o_store          output register captures the plaintext
//   o_sel[1:0]       datapath mux select (aes_pkg SEL_* codes)
//   o_round_key_idx  round-key index, 10 down to 0
//   o_col[1:0]       InvMixColumns column, 0 outside IMC
// -----------------------------------------------------------------------------
module aes_dec_ctrl
   import aes_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic       i_aes_start,
   input  logic       i_key_ready,
   output logic       o_aes_done,
   output logic       o_busy,
   output logic       o_key_go,
   output logic       o_load_msg,
   output logic       o_update,
   output logic       o_store,
   output logic [1:0] o_sel,
   output logic [3:0] o_round_key_idx,
   output logic [1:0] o_col
);

   aes_state_t r_state;
   aes_state_t w_next_state;
   logic [3:0] r_round;
   logic [1:0] r_col;
   logic       w_col_last;

   assign w_col_last = (r_col == COL_LAST);

   // Next-state selection.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (i_aes_start) begin
               w_next_state = ST_LOAD;
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         ST_LOAD:    w_next_state = ST_KEYWAIT;
         ST_KEYWAIT: begin
            if (i_key_ready) begin
               w_next_state = ST_ARK0;
            end else begin
               w_next_state = ST_KEYWAIT;
            end
         end
         ST_ARK0:    w_next_state = ST_ISR;
         ST_ISR:     w_next_state = ST_ISB;
         ST_ISB:     w_next_state = ST_ARK;
         ST_ARK:     w_next_state = ST_IMC;
         ST_IMC: begin
            // Leave only after the fourth column; round 9 hands over to the
            // final round, which skips InvMixColumns.
            if (!w_col_last) begin
               w_next_state = ST_IMC;
            end else if (r_round == LAST_LOOP_ROUND) begin
               w_next_state = ST_FISR;
            end else begin
               w_next_state = ST_ISR;
            end
         end
         ST_FISR:    w_next_state = ST_FISB;
         ST_FISB:    w_next_state = ST_FARK;
         ST_FARK:    w_next_state = ST_DONE;
         ST_DONE: begin
            // Holding here until start drops forces a fresh rising request.
            if (i_aes_start) begin
               w_next_state = ST_DONE;
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         default:    w_next_state = ST_IDLE;
      endcase
   end

   // State, round counter and column counter registers.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_state <= ST_IDLE;
         r_round <= 4'd0;
         r_col   <= 2'd0;
      end else begin
         r_state <= w_next_state;
         case (r_state)
            ST_ARK0: begin
               r_round <= 4'd1;
               r_col   <= r_col;
            end
            ST_ARK: begin
               // ARK always precedes IMC, so clear the column here.
               r_round <= r_round;
               r_col   <= 2'd0;
            end
            ST_IMC: begin
               if (w_col_last) begin
                  r_col <= 2'd0;
                  if (r_round < LAST_LOOP_ROUND) begin
                     r_round <= r_round + 4'd1;
                  end else begin
                     r_round <= r_round;
                  end
               end else begin
                  r_col   <= r_col + 2'd1;
                  r_round <= r_round;
               end
            end
            default: begin
               r_round <= r_round;
               r_col   <= r_col;
            end
         endcase
      end
   end

   // Output decode from the registered state and counters.
   always_comb begin
      o_aes_done      = 1'b0;
      o_busy          = 1'b0;
      o_key_go        = 1'b0;
      o_load_msg      = 1'b0;
      o_update        = 1'b0;
      o_store         = 1'b0;
      o_sel           = SEL_ARK;
      o_round_key_idx = 4'd0;
      o_col           = 2'd0;
      case (r_state)
         ST_IDLE: begin
            o_busy = 1'b0;
         end
         ST_LOAD: begin
            o_busy     = 1'b1;
            o_load_msg = 1'b1;
            o_key_go   = 1'b1;
         end
         ST_KEYWAIT: begin
            o_busy = 1'b1;
         end
         ST_ARK0: begin
            o_busy          = 1'b1;
            o_update        = 1'b1;
            o_sel           = SEL_ARK;
            o_round_key_idx = NUM_ROUNDS;
         end
         ST_ISR, ST_FISR: begin
            o_busy   = 1'b1;
            o_update = 1'b1;
            o_sel    = SEL_ISR;
         end
         ST_ISB, ST_FISB: begin
            o_busy   = 1'b1;
            o_update = 1'b1;
            o_sel    = SEL_ISB;
         end
         ST_ARK: begin
            o_busy          = 1'b1;
            o_update        = 1'b1;
            o_sel           = SEL_ARK;
            o_round_key_idx = NUM_ROUNDS - r_round;
         end
         ST_IMC: begin
            o_busy   = 1'b1;
            o_update = 1'b1;
            o_sel    = SEL_IMC;
            o_col    = r_col;
         end
         ST_FARK: begin
            o_busy          = 1'b1;
            o_update        = 1'b1;
            o_store         = 1'b1;
            o_sel           = SEL_ARK;
            o_round_key_idx = 4'd0;
         end
         ST_DONE: begin
            o_aes_done = 1'b1;
         end
         default: begin
            o_busy = 1'b0;
         end
      endcase
   end

endmodule

// File: doc/aes_dec_ctrl.md
AES_DEC_CTRL -- requirements
Module: aes_dec_ctrl

Interface
REQ-001 SHALL have no parameters; the round count is fixed at 10 (AES-128).
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RESET_N  input  1  synchronous, active-low reset.
REQ-004 AES_START  input  1  level request to decrypt; sampled only in IDLE and DONE.
REQ-005 AES_DONE  output  1  high while in DONE.
REQ-006 BUSY  output  1  high in every state except IDLE and DONE.
REQ-007 KEY_GO  output  1  one-cycle pulse that starts the key-expansion block.
REQ-008 KEY_READY  input  1  key schedule valid; sampled only in KEYWAIT.
REQ-009 LOAD_MSG  output  1  state register loads ciphertext this cycle.
REQ-010 UPDATE  output  1  state register loads datapath result this cycle.
REQ-011 STORE  output  1  output register captures datapath result (plaintext) this cycle.
REQ-012 SEL  output  2  datapath mux: 00 AddRoundKey, 01 InvShiftRows, 10 InvSubBytes, 11 InvMixColumns.
REQ-013 ROUND_KEY_IDX  output  4  round-key word index, 10 down to 0.
REQ-014 COL  output  2  InvMixColumns column select; 0 outside IMC.

Function
REQ-015 States: IDLE, LOAD, KEYWAIT, ARK0, ISR, ISB, ARK, IMC, FISR, FISB, FARK, DONE.
REQ-016 IDLE: all outputs 0; AES_START=1 -> LOAD.
REQ-017 LOAD, one cycle: LOAD_MSG=1, KEY_GO=1 -> KEYWAIT.
REQ-018 KEYWAIT: holds until KEY_READY=1, then -> ARK0; no timeout.
REQ-019 ARK0, one cycle: SEL=00, ROUND_KEY_IDX=10, UPDATE=1; round counter r set to 1 -> ISR.
REQ-020 Loop for r=1..9: ISR (SEL=01) -> ISB (SEL=10) -> ARK (SEL=00, ROUND_KEY_IDX=10-r) -> IMC.
REQ-021 Every loop state asserts UPDATE=1 for one cycle.
REQ-022 IMC lasts exactly 4 cycles: SEL=11, UPDATE=1, COL=0,1,2,3.
REQ-023 IMC exit after COL=3: to ISR with r+1 if r<9; to FISR if r=9.
REQ-024 Final round, one cycle each, UPDATE=1: FISR (SEL=01) -> FISB (SEL=10) -> FARK (SEL=00, ROUND_KEY_IDX=0, STORE=1) -> DONE.
REQ-025 DONE: AES_DONE=1; hold while AES_START=1; AES_START=0 -> IDLE.
REQ-026 A new operation requires AES_START to fall and rise again.
REQ-027 Latency, with KEY_READY=1 on first KEYWAIT cycle: DONE entered exactly 69 rising edges after the edge sampling AES_START=1 in IDLE.
REQ-028 Latency breakdown: LOAD 1 + KEYWAIT 1 + ARK0 1 + 9x7 + 3; each extra KEYWAIT cycle adds 1.
REQ-029 Changes on AES_START while BUSY SHALL be ignored.
REQ-030 Changes on KEY_READY outside KEYWAIT SHALL be ignored.
REQ-031 Counters SHALL never wrap: r is 4 bits, range 1..9; column counter is 2 bits, cleared on IMC entry.
REQ-032 All outputs SHALL be registered or decoded from the state register only; no combinational path from inputs to outputs.

Reset
REQ-033 RESET_N=0 at a rising edge -> IDLE, r=0, column counter=0, all outputs 0, in any state including mid-round.
REQ-034 While RESET_N=0, AES_START SHALL be ignored.
REQ-035 After RESET_N returns to 1, AES_START=1 SHALL start a fresh operation with full latency.

Structure
REQ-036 Package aes_pkg SHALL hold the state enum, the SEL encoding constants, NUM_ROUNDS=10 and MIX_COLS=4.
REQ-037 The datapath SHALL consume SEL, COL and ROUND_KEY_IDX from aes_pkg constants only.
REQ-038 Single module: one FSM plus round and column counters; no sub-module (expected 150-250 lines).

Verification
REQ-039 Reset, then AES_START=1 held, KEY_READY=1 -> KEY_GO and LOAD_MSG pulse once; AES_DONE rises at edge 69; STORE high exactly 1 cycle, at edge 68.
REQ-040 Same run, log (SEL, ROUND_KEY_IDX, COL) every cycle -> ARK idx 10, then 9 x [ISR, ISB, ARK idx 9..1, IMC col 0-3], then ISR, ISB, ARK idx 0; UPDATE count = 67.
REQ-041 KEY_READY withheld 5 cycles -> KEYWAIT holds 6 cycles; AES_DONE at edge 74.
REQ-042 RESET_N=0 for one edge during r=4 IMC COL=2 -> next cycle IDLE with all outputs 0; restart completes in 69.
REQ-043 AES_START toggled 0/1 during BUSY -> no effect on sequence; AES_START held after DONE -> stays DONE; then drop -> IDLE; re-raise -> new run.
REQ-044 System bench with datapath: KEY 000102030405060708090a0b0c0d0e0f, ciphertext daec3055df058e1c39e814ea76f6747e -> AES_MSG_DEC equals the golden-model plaintext on AES_DONE.
